// File: rtl/ctrl_pkg.sv
// Shared encodings for the control pipeline: opcodes, immediate and result
// selects, ALU operations, the per-stage control bundle and the div FSM states.
package ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } res_src_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src;
        res_src_e   result_src;
        logic [3:0] alu_ctrl;
        logic [2:0] funct3;
    } ctrl_t;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_e;

    // Returns {supported, alu_code} for the base integer funct3 set.
    function automatic logic [4:0] alu_base(
        input logic [2:0] f3,
        input logic       sub
    );
        logic [4:0] r;
        case (f3)
            3'b000:  r = {1'b1, sub ? ALU_SUB : ALU_ADD};
            3'b010:  r = {1'b1, ALU_SLT};
            3'b110:  r = {1'b1, ALU_OR};
            3'b111:  r = {1'b1, ALU_AND};
            default: r = {1'b0, ALU_ADD};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_ctrl_gen_if.sv
// Bundle of the pipe_ctrl_gen hazard/decode signals for wiring.
// master drives flush/stall/branch/instruction, slave returns control.
interface pipe_ctrl_gen_if #(
    parameter int ALU_CTRL_W = 3
);
    logic                  FlushE;
    logic                  StallE;
    logic                  branch_taken;
    logic [31:0]           InstrD;
    logic [2:0]            ImmSrcD;
    logic                  IllegalD;
    logic                  ALUSrcE;
    logic                  PCSrcE;
    logic [1:0]            ResultSrcE;
    logic [ALU_CTRL_W-1:0] ALUControlE;
    logic [2:0]            functE;
    logic [2:0]            functM;
    logic                  BusyE;
    logic                  MemWriteM;
    logic                  RegWriteM;
    logic                  RegWriteW;
    logic [1:0]            ResultSrcW;

    modport master (
        output FlushE, StallE, branch_taken, InstrD,
        input  ImmSrcD, IllegalD, ALUSrcE, PCSrcE,
        input  ResultSrcE, ALUControlE, functE, functM,
        input  BusyE, MemWriteM, RegWriteM, RegWriteW,
        input  ResultSrcW
    );

    modport slave (
        input  FlushE, StallE, branch_taken, InstrD,
        output ImmSrcD, IllegalD, ALUSrcE, PCSrcE,
        output ResultSrcE, ALUControlE, functE, functM,
        output BusyE, MemWriteM, RegWriteM, RegWriteW,
        output ResultSrcW
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational D-stage decoder: instruction -> control bundle.
// Ports: instr_i in; ctrl_o, imm_src_o, illegal_o out.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit MEXT_EN = 1'b0
) (
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output imm_src_e    imm_src_o,
    output logic        illegal_o
);

    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] alu_r;
    logic [4:0] alu_i;
    logic       unused_bits;

    assign op    = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign alu_r = alu_base(f3, f7[5]);
    assign alu_i = alu_base(f3, 1'b0);

    // Register fields are not needed for control.
    assign unused_bits = ^{instr_i[24:15], instr_i[11:7]};

    ctrl_t    c;
    imm_src_e imm;
    logic     ill;

    always_comb begin
        c        = '0;
        imm      = IMM_I;
        ill      = 1'b0;
        c.funct3 = f3;
        case (op)
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.result_src = RES_MEM;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                imm         = IMM_S;
            end
            OP_R: begin
                c.reg_write = 1'b1;
                if (f7 == F7_MEXT) begin
                    if (MEXT_EN) c.alu_ctrl = {1'b1, f3};
                    else         ill = 1'b1;
                end else if (f7 != F7_BASE && f7 != F7_SUB) begin
                    ill = 1'b1;
                end else begin
                    c.alu_ctrl = alu_r[3:0];
                    ill        = ~alu_r[4];
                end
            end
            OP_I: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = alu_i[3:0];
                ill         = ~alu_i[4];
            end
            OP_BR: begin
                c.branch   = 1'b1;
                c.alu_ctrl = ALU_SUB;
                imm        = IMM_B;
            end
            OP_JAL: begin
                c.reg_write  = 1'b1;
                c.jump       = 1'b1;
                c.result_src = RES_PC4;
                imm          = IMM_J;
            end
            OP_LUI: begin
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.result_src = RES_IMM;
                imm          = IMM_U;
            end
            default: ill = 1'b1;
        endcase
        // Unsupported encodings must not change architectural state.
        if (ill) begin
            c.reg_write = 1'b0;
            c.mem_write = 1'b0;
            c.branch    = 1'b0;
            c.jump      = 1'b0;
        end
    end

    assign ctrl_o    = c;
    assign imm_src_o = imm;
    assign illegal_o = ill;

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Control pipeline D->E->M->W with a multi-cycle div/rem hold in E.
// Ports: clk, reset (async low), hazard inputs, InstrD; staged controls out.
module pipe_ctrl_gen
    import ctrl_pkg::*;
#(
    parameter bit MEXT_EN    = 1'b0,
    parameter int ALU_CTRL_W = 3,
    parameter int DIV_LAT    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  FlushE,
    input  logic                  StallE,
    input  logic                  branch_taken,
    input  logic [31:0]           InstrD,
    output logic [2:0]            ImmSrcD,
    output logic                  IllegalD,
    output logic                  ALUSrcE,
    output logic                  PCSrcE,
    output logic [1:0]            ResultSrcE,
    output logic [ALU_CTRL_W-1:0] ALUControlE,
    output logic [2:0]            functE,
    output logic [2:0]            functM,
    output logic                  BusyE,
    output logic                  MemWriteM,
    output logic                  RegWriteM,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW
);

    localparam logic [4:0] CNT_LOAD = 5'(DIV_LAT - 1);

    ctrl_t      ctrl_d;
    imm_src_e   imm_d;
    ctrl_t      e_q;
    logic       m_rw_q;
    logic       m_mw_q;
    logic [1:0] m_rs_q;
    logic [2:0] m_f3_q;
    logic       w_rw_q;
    logic [1:0] w_rs_q;
    div_state_e state_q;
    logic [4:0] cnt_q;
    logic       div_e;
    logic       hold;

    ctrl_decode #(
        .MEXT_EN (MEXT_EN)
    ) u_dec (
        .instr_i   (InstrD),
        .ctrl_o    (ctrl_d),
        .imm_src_o (imm_d),
        .illegal_o (IllegalD)
    );

    assign ImmSrcD = imm_d;

    assign div_e = e_q.alu_ctrl[3] & e_q.funct3[2];

    // Busy covers the entry cycle plus all BUSY cycles but the last,
    // giving DIV_LAT-1 held cycles and DIV_LAT cycles in E.
    assign BusyE = (state_q == DIV_IDLE && div_e)
                || (state_q == DIV_BUSY && cnt_q != 5'd1);
    assign hold  = StallE | BusyE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else if (FlushE) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (div_e) begin
                        state_q <= DIV_BUSY;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                DIV_BUSY: begin
                    // Stay parked at 1 while stalled so the op is not
                    // re-launched when the FSM would see it again in IDLE.
                    if (cnt_q == 5'd1) begin
                        if (!StallE) state_q <= DIV_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                default: state_q <= DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q    <= '0;
            m_rw_q <= 1'b0;
            m_mw_q <= 1'b0;
            m_rs_q <= '0;
            m_f3_q <= '0;
            w_rw_q <= 1'b0;
            w_rs_q <= '0;
        end else begin
            if (FlushE)     e_q <= '0;
            else if (!hold) e_q <= ctrl_d;
            if (hold) begin
                m_rw_q <= 1'b0;
                m_mw_q <= 1'b0;
                m_rs_q <= '0;
                m_f3_q <= '0;
            end else begin
                m_rw_q <= e_q.reg_write;
                m_mw_q <= e_q.mem_write;
                m_rs_q <= e_q.result_src;
                m_f3_q <= e_q.funct3;
            end
            w_rw_q <= m_rw_q;
            w_rs_q <= m_rs_q;
        end
    end

    assign ALUSrcE     = e_q.alu_src;
    assign PCSrcE      = (e_q.branch & branch_taken) | e_q.jump;
    assign ResultSrcE  = e_q.result_src;
    assign ALUControlE = e_q.alu_ctrl[ALU_CTRL_W-1:0];
    assign functE      = e_q.funct3;
    assign functM      = m_f3_q;
    assign MemWriteM   = m_mw_q;
    assign RegWriteM   = m_rw_q;
    assign RegWriteW   = w_rw_q;
    assign ResultSrcW  = w_rs_q;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed bench for pipe_ctrl_gen: base config (dut0) and RV32M
// config with DIV_LAT=4 (dut1), each wired through pipe_ctrl_gen_if.
module tb_pipe_ctrl_gen;

    localparam logic [31:0] ADD = 32'h002081B3;
    localparam logic [31:0] SUB = 32'h40208133;
    localparam logic [31:0] ORR = 32'h0020E1B3;
    localparam logic [31:0] LW  = 32'h0000A283;
    localparam logic [31:0] SW  = 32'h0050A023;
    localparam logic [31:0] BEQ = 32'h00000463;
    localparam logic [31:0] JAL = 32'h000000EF;
    localparam logic [31:0] LUI = 32'h000000B7;
    localparam logic [31:0] DIV = 32'h0220C1B3;
    localparam logic [31:0] MUL = 32'h022081B3;
    localparam logic [31:0] BAD = 32'h0000007F;
    localparam logic [31:0] BUB = 32'h00000000;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    pipe_ctrl_gen_if #(.ALU_CTRL_W(3)) b0 ();
    pipe_ctrl_gen_if #(.ALU_CTRL_W(4)) b1 ();

    pipe_ctrl_gen #(
        .MEXT_EN(1'b0), .ALU_CTRL_W(3), .DIV_LAT(4)
    ) dut0 (
        .clk(clk), .reset(reset),
        .FlushE(b0.FlushE), .StallE(b0.StallE),
        .branch_taken(b0.branch_taken), .InstrD(b0.InstrD),
        .ImmSrcD(b0.ImmSrcD), .IllegalD(b0.IllegalD),
        .ALUSrcE(b0.ALUSrcE), .PCSrcE(b0.PCSrcE),
        .ResultSrcE(b0.ResultSrcE), .ALUControlE(b0.ALUControlE),
        .functE(b0.functE), .functM(b0.functM), .BusyE(b0.BusyE),
        .MemWriteM(b0.MemWriteM), .RegWriteM(b0.RegWriteM),
        .RegWriteW(b0.RegWriteW), .ResultSrcW(b0.ResultSrcW)
    );

    pipe_ctrl_gen #(
        .MEXT_EN(1'b1), .ALU_CTRL_W(4), .DIV_LAT(4)
    ) dut1 (
        .clk(clk), .reset(reset),
        .FlushE(b1.FlushE), .StallE(b1.StallE),
        .branch_taken(b1.branch_taken), .InstrD(b1.InstrD),
        .ImmSrcD(b1.ImmSrcD), .IllegalD(b1.IllegalD),
        .ALUSrcE(b1.ALUSrcE), .PCSrcE(b1.PCSrcE),
        .ResultSrcE(b1.ResultSrcE), .ALUControlE(b1.ALUControlE),
        .functE(b1.functE), .functM(b1.functM), .BusyE(b1.BusyE),
        .MemWriteM(b1.MemWriteM), .RegWriteM(b1.RegWriteM),
        .RegWriteW(b1.RegWriteW), .ResultSrcW(b1.ResultSrcW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        b0.InstrD = ADD;
        b1.InstrD = DIV;
        repeat (2) tick();
        total++;
        if ({b0.ALUSrcE, b0.PCSrcE, b0.ResultSrcE, b0.ALUControlE,
             b0.functE, b0.functM, b0.BusyE, b0.MemWriteM,
             b0.RegWriteM, b0.RegWriteW, b0.ResultSrcW} !== '0) begin
            bad++;
            $display("FAIL reset_dut0 got=%0h exp=0",
                {b0.ALUSrcE, b0.PCSrcE, b0.ResultSrcE, b0.ALUControlE,
                 b0.functE, b0.functM, b0.BusyE, b0.MemWriteM,
                 b0.RegWriteM, b0.RegWriteW, b0.ResultSrcW});
        end
        total++;
        if ({b1.ALUControlE, b1.functE, b1.BusyE,
             b1.RegWriteM, b1.RegWriteW} !== '0) begin
            bad++;
            $display("FAIL reset_dut1 got=%0h exp=0",
                {b1.ALUControlE, b1.functE, b1.BusyE,
                 b1.RegWriteM, b1.RegWriteW});
        end
        b0.InstrD = BUB;
        b1.InstrD = BUB;
        tick();
        reset = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_add;
        b0.InstrD = ADD;
        #1;
        total++;
        if ({b0.ImmSrcD, b0.IllegalD} !== 4'b0000) begin
            bad++;
            $display("FAIL add_decode got=%0h exp=0",
                {b0.ImmSrcD, b0.IllegalD});
        end
        tick();
        b0.InstrD = BUB;
        total++;
        if ({b0.ALUSrcE, b0.ALUControlE, b0.RegWriteW} !== 5'b0) begin
            bad++;
            $display("FAIL add_e got=%0h exp=0",
                {b0.ALUSrcE, b0.ALUControlE, b0.RegWriteW});
        end
        tick();
        total++;
        if ({b0.RegWriteM, b0.RegWriteW} !== 2'b10) begin
            bad++;
            $display("FAIL add_m got=%0b exp=10",
                {b0.RegWriteM, b0.RegWriteW});
        end
        tick();
        total++;
        if ({b0.RegWriteW, b0.ResultSrcW} !== 3'b100) begin
            bad++;
            $display("FAIL add_w got=%0b exp=100",
                {b0.RegWriteW, b0.ResultSrcW});
        end
        repeat (2) tick();
    endtask

    task automatic test_alu_ops;
        b0.InstrD = SUB;
        tick();
        b0.InstrD = ORR;
        total++;
        if (b0.ALUControlE !== 3'b001) begin
            bad++;
            $display("FAIL sub_alu got=%0b exp=001", b0.ALUControlE);
        end
        tick();
        b0.InstrD = BUB;
        total++;
        if (b0.ALUControlE !== 3'b011) begin
            bad++;
            $display("FAIL or_alu got=%0b exp=011", b0.ALUControlE);
        end
        repeat (3) tick();
    endtask

    task automatic test_load_store;
        b0.InstrD = LW;
        #1;
        total++;
        if (b0.ImmSrcD !== 3'b000) begin
            bad++;
            $display("FAIL lw_imm got=%0b exp=000", b0.ImmSrcD);
        end
        tick();
        b0.InstrD = SW;
        #1;
        total++;
        if (b0.ImmSrcD !== 3'b001) begin
            bad++;
            $display("FAIL sw_imm got=%0b exp=001", b0.ImmSrcD);
        end
        total++;
        if ({b0.ALUSrcE, b0.ResultSrcE} !== 3'b101) begin
            bad++;
            $display("FAIL lw_e got=%0b exp=101",
                {b0.ALUSrcE, b0.ResultSrcE});
        end
        tick();
        b0.InstrD = BUB;
        total++;
        if ({b0.MemWriteM, b0.RegWriteM} !== 2'b01) begin
            bad++;
            $display("FAIL lw_m got=%0b exp=01",
                {b0.MemWriteM, b0.RegWriteM});
        end
        tick();
        total++;
        if ({b0.MemWriteM, b0.RegWriteW, b0.ResultSrcW} !== 4'b1101) begin
            bad++;
            $display("FAIL sw_m_lw_w got=%0b exp=1101",
                {b0.MemWriteM, b0.RegWriteW, b0.ResultSrcW});
        end
        tick();
        total++;
        if (b0.MemWriteM !== 1'b0) begin
            bad++;
            $display("FAIL sw_one_cycle got=%0b exp=0", b0.MemWriteM);
        end
        repeat (2) tick();
    endtask

    task automatic test_branch;
        b0.InstrD = BEQ;
        #1;
        total++;
        if (b0.ImmSrcD !== 3'b010) begin
            bad++;
            $display("FAIL beq_imm got=%0b exp=010", b0.ImmSrcD);
        end
        tick();
        b0.InstrD = BUB;
        b0.branch_taken = 1'b1;
        #1;
        total++;
        if (b0.PCSrcE !== 1'b1) begin
            bad++;
            $display("FAIL beq_taken got=%0b exp=1", b0.PCSrcE);
        end
        tick();
        total++;
        if ({b0.PCSrcE, b0.RegWriteM} !== 2'b00) begin
            bad++;
            $display("FAIL beq_after got=%0b exp=00",
                {b0.PCSrcE, b0.RegWriteM});
        end
        b0.branch_taken = 1'b0;
        b0.InstrD = BEQ;
        tick();
        b0.InstrD = BUB;
        #1;
        total++;
        if (b0.PCSrcE !== 1'b0) begin
            bad++;
            $display("FAIL beq_not_taken got=%0b exp=0", b0.PCSrcE);
        end
        repeat (3) tick();
    endtask

    task automatic test_jal_lui;
        b0.InstrD = JAL;
        #1;
        total++;
        if (b0.ImmSrcD !== 3'b011) begin
            bad++;
            $display("FAIL jal_imm got=%0b exp=011", b0.ImmSrcD);
        end
        tick();
        b0.InstrD = LUI;
        #1;
        total++;
        if ({b0.PCSrcE, b0.ImmSrcD} !== 4'b1100) begin
            bad++;
            $display("FAIL jal_pc_lui_imm got=%0b exp=1100",
                {b0.PCSrcE, b0.ImmSrcD});
        end
        tick();
        b0.InstrD = BUB;
        tick();
        total++;
        if ({b0.RegWriteW, b0.ResultSrcW} !== 3'b110) begin
            bad++;
            $display("FAIL jal_w got=%0b exp=110",
                {b0.RegWriteW, b0.ResultSrcW});
        end
        tick();
        total++;
        if ({b0.RegWriteW, b0.ResultSrcW} !== 3'b111) begin
            bad++;
            $display("FAIL lui_w got=%0b exp=111",
                {b0.RegWriteW, b0.ResultSrcW});
        end
        repeat (2) tick();
    endtask

    task automatic test_illegal;
        b0.InstrD = MUL;
        #1;
        total++;
        if (b0.IllegalD !== 1'b1) begin
            bad++;
            $display("FAIL mul_no_mext got=%0b exp=1", b0.IllegalD);
        end
        tick();
        b0.InstrD = BAD;
        #1;
        total++;
        if (b0.IllegalD !== 1'b1) begin
            bad++;
            $display("FAIL bad_opcode got=%0b exp=1", b0.IllegalD);
        end
        tick();
        b0.InstrD = BUB;
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({b0.RegWriteM, b0.RegWriteW, b0.MemWriteM,
                 b0.PCSrcE} !== 4'b0) begin
                bad++;
                $display("FAIL illegal_quiet c=%0d got=%0b exp=0", c,
                    {b0.RegWriteM, b0.RegWriteW, b0.MemWriteM, b0.PCSrcE});
            end
            tick();
        end
    endtask

    task automatic test_stall_flush;
        b0.InstrD = SUB;
        tick();
        b0.InstrD = BUB;
        b0.StallE = 1'b1;
        tick();
        total++;
        if ({b0.ALUControlE, b0.RegWriteM} !== 4'b0010) begin
            bad++;
            $display("FAIL stall_hold got=%0b exp=0010",
                {b0.ALUControlE, b0.RegWriteM});
        end
        b0.FlushE = 1'b1;
        tick();
        b0.FlushE = 1'b0;
        b0.StallE = 1'b0;
        total++;
        if ({b0.ALUControlE, b0.RegWriteM} !== 4'b0000) begin
            bad++;
            $display("FAIL flush_wins got=%0b exp=0000",
                {b0.ALUControlE, b0.RegWriteM});
        end
        tick();
        tick();
        total++;
        if ({b0.RegWriteM, b0.RegWriteW} !== 2'b00) begin
            bad++;
            $display("FAIL flushed_no_write got=%0b exp=00",
                {b0.RegWriteM, b0.RegWriteW});
        end
        repeat (2) tick();
    endtask

    task automatic test_div;
        b1.InstrD = DIV;
        tick();
        b1.InstrD = BUB;
        total++;
        if (b1.ALUControlE !== 4'b1100) begin
            bad++;
            $display("FAIL div_alu got=%0b exp=1100", b1.ALUControlE);
        end
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) tick();
            total++;
            if (b1.BusyE !== (c <= 3)) begin
                bad++;
                $display("FAIL div_busy c=%0d got=%0b exp=%0b",
                    c, b1.BusyE, (c <= 3));
            end
            total++;
            if (b1.RegWriteM !== (c == 5)) begin
                bad++;
                $display("FAIL div_rwm c=%0d got=%0b exp=%0b",
                    c, b1.RegWriteM, (c == 5));
            end
            total++;
            if (b1.RegWriteW !== (c == 6)) begin
                bad++;
                $display("FAIL div_rww c=%0d got=%0b exp=%0b",
                    c, b1.RegWriteW, (c == 6));
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_mul;
        b1.InstrD = MUL;
        tick();
        b1.InstrD = BUB;
        total++;
        if ({b1.BusyE, b1.ALUControlE} !== 5'b01000) begin
            bad++;
            $display("FAIL mul_e got=%0b exp=01000",
                {b1.BusyE, b1.ALUControlE});
        end
        tick();
        total++;
        if ({b1.BusyE, b1.RegWriteM} !== 2'b01) begin
            bad++;
            $display("FAIL mul_m got=%0b exp=01",
                {b1.BusyE, b1.RegWriteM});
        end
        repeat (3) tick();
    endtask

    task automatic test_back_to_back;
        logic exp_b;
        b1.InstrD = DIV;
        tick();
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) tick();
            if (c == 5) b1.InstrD = BUB;
            exp_b = (c <= 3) || (c >= 5 && c <= 7);
            total++;
            if (b1.BusyE !== exp_b) begin
                bad++;
                $display("FAIL b2b_busy c=%0d got=%0b exp=%0b",
                    c, b1.BusyE, exp_b);
            end
            total++;
            if (b1.RegWriteM !== (c == 5)) begin
                bad++;
                $display("FAIL b2b_rwm c=%0d got=%0b exp=%0b",
                    c, b1.RegWriteM, (c == 5));
            end
        end
        tick();
        total++;
        if (b1.RegWriteM !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second_retire got=%0b exp=1",
                b1.RegWriteM);
        end
        repeat (3) tick();
    endtask

    task automatic test_flush_busy;
        int nbusy;
        b1.InstrD = DIV;
        tick();
        b1.InstrD = BUB;
        tick();
        b1.FlushE = 1'b1;
        tick();
        b1.FlushE = 1'b0;
        total++;
        if ({b1.BusyE, b1.ALUControlE} !== 5'b0) begin
            bad++;
            $display("FAIL flush_abort got=%0b exp=0",
                {b1.BusyE, b1.ALUControlE});
        end
        for (int c = 0; c < 4; c++) begin
            total++;
            if ({b1.BusyE, b1.RegWriteM, b1.RegWriteW} !== 3'b0) begin
                bad++;
                $display("FAIL flush_quiet c=%0d got=%0b exp=0", c,
                    {b1.BusyE, b1.RegWriteM, b1.RegWriteW});
            end
            tick();
        end
        nbusy = 0;
        b1.InstrD = DIV;
        tick();
        b1.InstrD = BUB;
        for (int c = 0; c < 6; c++) begin
            if (b1.BusyE === 1'b1) nbusy++;
            tick();
        end
        total++;
        if (nbusy != 3) begin
            bad++;
            $display("FAIL flush_then_div got=%0d exp=3", nbusy);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_busy;
        b1.InstrD = DIV;
        tick();
        b1.InstrD = BUB;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if ({b1.BusyE, b1.ALUControlE, b1.RegWriteM,
             b1.RegWriteW} !== 7'b0) begin
            bad++;
            $display("FAIL reset_abort got=%0b exp=0",
                {b1.BusyE, b1.ALUControlE, b1.RegWriteM, b1.RegWriteW});
        end
        tick();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if ({b1.BusyE, b1.RegWriteM, b1.RegWriteW} !== 3'b0) begin
                bad++;
                $display("FAIL reset_quiet c=%0d got=%0b exp=0", c,
                    {b1.BusyE, b1.RegWriteM, b1.RegWriteW});
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        b0.FlushE = 1'b0;
        b0.StallE = 1'b0;
        b0.branch_taken = 1'b0;
        b0.InstrD = BUB;
        b1.FlushE = 1'b0;
        b1.StallE = 1'b0;
        b1.branch_taken = 1'b0;
        b1.InstrD = BUB;
        test_reset();
        test_add();
        test_alu_ops();
        test_load_store();
        test_branch();
        test_jal_lui();
        test_illegal();
        test_stall_flush();
        test_div();
        test_mul();
        test_back_to_back();
        test_flush_busy();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_gen.md
PIPE_CTRL_GEN -- requirements
Module: pipe_ctrl_gen

Interface
REQ-001 The block SHALL have parameter MEXT_EN, default 0, which enables RV32M decode when 1.
REQ-002 The block SHALL have parameter ALU_CTRL_W, default 3, giving the ALU control width; it SHALL be 4 when MEXT_EN=1.
REQ-003 The block SHALL have parameter DIV_LAT, default 4, range 2..16, giving the E-stage cycles of a div/rem.
REQ-004 Ports, in order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- FlushE  in  1  bubble the D->E register.
- StallE  in  1  external hold of the E register.
- branch_taken  in  1  branch comparison result, E stage.
- InstrD  in  32  decode-stage instruction.
- ImmSrcD  out  3  immediate format.
- IllegalD  out  1  unsupported encoding in D.
- ALUSrcE  out  1  select immediate for ALU B.
- PCSrcE  out  1  redirect PC.
- ResultSrcE  out  2  result select, E copy.
- ALUControlE  out  ALU_CTRL_W  ALU operation.
- functE  out  3  funct3, E stage.
- functM  out  3  funct3, M stage.
- BusyE  out  1  multi-cycle op holds E.
- MemWriteM  out  1  store enable.
- RegWriteM  out  1  register write, M stage.
- RegWriteW  out  1  register write, W stage.
- ResultSrcW  out  2  result select, W stage.

Function
REQ-005 Decode SHALL be combinational in D, covering these opcodes:
- lw 0000011
- sw 0100011
- R 0110011
- I-ALU 0010011
- branch 1100011
- jal 1101111
- lui 0110111
REQ-006 ImmSrcD encoding SHALL be: I=000, S=001, B=010, J=011, U=100.
REQ-007 ResultSrc encoding SHALL be: 00 ALU, 01 memory, 10 PC+4, 11 immediate (lui).
REQ-008 Base ALUControl encoding SHALL be: 000 add, 001 sub, 010 and, 011 or, 101 slt. Sub SHALL be selected for R-type with funct7[5]=1 and for branches. Load, store and jal SHALL use add. When ALU_CTRL_W=4, base codes SHALL be zero-extended.
REQ-009 With MEXT_EN=1, R-type with funct7=0000001 SHALL produce ALUControl={1,funct3}. With MEXT_EN=0 the same encoding SHALL set IllegalD.
REQ-010 On an unknown opcode, IllegalD SHALL be 1 and RegWrite, MemWrite, Branch and Jump SHALL be forced to 0.
REQ-011 Control SHALL be registered D->E, E->M and M->W. RegWriteW SHALL therefore follow the instruction's D cycle by exactly 3 clocks when no stall occurs.
REQ-012 PCSrcE SHALL equal (BranchE AND branch_taken) OR JumpE, combinationally.
REQ-013 FlushE SHALL load zeros into the E register. FlushE SHALL win over StallE.
REQ-014 StallE or BusyE SHALL hold the E register. While E is held, the M register SHALL receive a bubble (RegWriteM=0, MemWriteM=0).
REQ-015 The div FSM SHALL have two states, IDLE and BUSY.
- IDLE->BUSY: when an E instruction has ALUControlE[3]=1 and functE[2]=1; the counter loads DIV_LAT-1.
- In BUSY: the counter decrements each clock.
- BUSY->IDLE: when the counter reaches 1; the op then advances to M on the next edge.
REQ-016 BusyE SHALL be high exactly DIV_LAT-1 consecutive cycles per div/rem, starting in the cycle the op enters E.
REQ-017 mul ops (functE[2]=0) SHALL be single-cycle and SHALL never raise BusyE.
REQ-018 FlushE asserted in BUSY SHALL abort the op, force IDLE and bubble E, all on the same edge.
REQ-019 Back-to-back div ops SHALL each incur their full latency, with no overlap.

Reset
REQ-020 Asserting reset low SHALL asynchronously clear every pipeline register, the counter and the FSM (to IDLE).
REQ-021 Every registered output SHALL therefore read 0 during reset.
REQ-022 Reset deassertion SHALL be synchronised externally.
REQ-023 Reset mid-division SHALL leave no residual BusyE.

Structure
REQ-024 Opcodes, ImmSrc, ResultSrc and ALUControl encodings SHALL reside in the shared package ctrl_pkg.
REQ-025 Combinational decode SHALL be the sub-module ctrl_decode. The pipeline registers and the FSM SHALL reside in pipe_ctrl_gen.

Verification
REQ-026 InstrD=0x002081B3 (add) -> 3 clocks later: RegWriteW=1, ResultSrcW=00; ALUControlE=000.
REQ-027 lw 0x0000A283, then sw 0x0050A023 -> ResultSrcW=01 for lw; MemWriteM=1 exactly one cycle for sw; ImmSrcD=000 then 001.
REQ-028 beq 0x00000463 with branch_taken=1 -> PCSrcE=1 for one cycle, RegWriteM=0. With branch_taken=0 -> PCSrcE=0.
REQ-029 MEXT_EN=1, DIV_LAT=4, div 0x0220C1B3 -> BusyE high 3 cycles, RegWriteM bubbles for 3 cycles, then RegWriteM=1. mul 0x022081B3 -> BusyE stays 0.
REQ-030 MEXT_EN=0, InstrD=0x022081B3 -> IllegalD=1, RegWriteW stays 0.
REQ-031 Scenario: FlushE pulse in the 2nd BUSY cycle, and separately reset low in the 2nd BUSY cycle -> BusyE=0 immediately, FSM IDLE, no register write.
